// File: rtl/sorter_pkg.sv
// sorter_pkg: shared constants and types for the bottom_sorter block.
//   KEY_W       : default key width in bits
//   key_t       : one unsigned key
//   lanes_t     : four keys, lane 1 at index 0
//   SORT_STAGES : register stages through the network (latency in cycles)
package sorter_pkg;

    localparam int KEY_W       = 4;
    localparam int SORT_STAGES = 4;

    typedef logic [KEY_W-1:0] key_t;
    typedef key_t [3:0]       lanes_t;

endpackage

// File: rtl/cmp_swap.sv
// cmp_swap: combinational compare-exchange of two unsigned keys.
//   a, b   : input keys (a is the lower lane)
//   lo, hi : outputs for the lower / upper lane
// Build option SORTER_DESCENDING_EN: swap on a < b, so larger keys move
// toward the lower lane. Default: swap on a > b. Equal keys never swap.
module cmp_swap
    import sorter_pkg::*;
#(
    parameter int W = KEY_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);

    logic swap;

`ifdef SORTER_DESCENDING_EN
    assign swap = (a < b);
`else
    assign swap = (a > b);
`endif

    assign lo = swap ? b : a;
    assign hi = swap ? a : b;

endmodule

// File: rtl/bottom_sorter.sv
// bottom_sorter: 4-lane odd-even transposition sorter, one register stage
// per phase, one vector per clock, fixed latency of SORT_STAGES cycles.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid, i1..i4  : input vector and its qualifier
//   out_valid, o1..o4 : sorted vector (o1 smallest) and its qualifier
// Build option SORTER_DESCENDING_EN (inside cmp_swap) reverses the order.
// Data stages load every cycle; only the valid pipe carries qualification.
module bottom_sorter
    import sorter_pkg::*;
#(
    parameter int W = KEY_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] i1,
    input  logic [W-1:0] i2,
    input  logic [W-1:0] i3,
    input  logic [W-1:0] i4,
    output logic         out_valid,
    output logic [W-1:0] o1,
    output logic [W-1:0] o2,
    output logic [W-1:0] o3,
    output logic [W-1:0] o4
);

    typedef logic [3:0][W-1:0] stage_t;

    stage_t p1, p2, p3, p4;
    stage_t s1, s2, s3, s4;
    logic [SORT_STAGES-1:0] vld;

    // phase 1: pairs (1,2) and (3,4) on raw inputs
    cmp_swap #(.W(W)) u_ce1a (.a(i1), .b(i2), .lo(p1[0]), .hi(p1[1]));
    cmp_swap #(.W(W)) u_ce1b (.a(i3), .b(i4), .lo(p1[2]), .hi(p1[3]));

    // phase 2: middle pair, outer lanes pass through
    assign p2[0] = s1[0];
    assign p2[3] = s1[3];
    cmp_swap #(.W(W)) u_ce2  (.a(s1[1]), .b(s1[2]), .lo(p2[1]), .hi(p2[2]));

    // phase 3: pairs (1,2) and (3,4)
    cmp_swap #(.W(W)) u_ce3a (.a(s2[0]), .b(s2[1]), .lo(p3[0]), .hi(p3[1]));
    cmp_swap #(.W(W)) u_ce3b (.a(s2[2]), .b(s2[3]), .lo(p3[2]), .hi(p3[3]));

    // phase 4: middle pair, outer lanes pass through
    assign p4[0] = s3[0];
    assign p4[3] = s3[3];
    cmp_swap #(.W(W)) u_ce4  (.a(s3[1]), .b(s3[2]), .lo(p4[1]), .hi(p4[2]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= '0;
            s2  <= '0;
            s3  <= '0;
            s4  <= '0;
            vld <= '0;
        end else begin
            s1  <= p1;
            s2  <= p2;
            s3  <= p3;
            s4  <= p4;
            vld <= {vld[SORT_STAGES-2:0], in_valid};
        end
    end

    assign out_valid = vld[SORT_STAGES-1];
    assign o1 = s4[0];
    assign o2 = s4[1];
    assign o3 = s4[2];
    assign o4 = s4[3];

endmodule

// File: tb/tb_bottom_sorter.sv
// tb_bottom_sorter: directed and random stimulus for bottom_sorter, checked
// against a reference that sorts each sampled vector with a queue sort and
// releases it SORT_STAGES edges later. Build option SORTER_DESCENDING_EN is
// honoured by the reference as well.
module tb_bottom_sorter;

    localparam int W   = 4;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] i1 = '0, i2 = '0, i3 = '0, i4 = '0;
    logic         out_valid;
    logic [W-1:0] o1, o2, o3, o4;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    typedef struct packed {
        logic        v;
        logic [15:0] d;
    } exp_t;

    exp_t pipe[$];

    bottom_sorter #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .i1       (i1),
        .i2       (i2),
        .i3       (i3),
        .i4       (i4),
        .out_valid(out_valid),
        .o1       (o1),
        .o2       (o2),
        .o3       (o3),
        .o4       (o4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // software sort of a packed {lane1,lane2,lane3,lane4} vector
    function automatic logic [15:0] ref_sort(input logic [15:0] d);
        int q[$];
        logic [15:0] r;
        for (int i = 0; i < 4; i++) q.push_back(int'(d[15-4*i -: 4]));
`ifdef SORTER_DESCENDING_EN
        q.rsort();
`else
        q.sort();
`endif
        r = {4'(q[0]), 4'(q[1]), 4'(q[2]), 4'(q[3])};
        return r;
    endfunction

    // ascending constant -> expectation for the current build
    function automatic logic [15:0] build_exp(input logic [15:0] asc);
`ifdef SORTER_DESCENDING_EN
        return {asc[3:0], asc[7:4], asc[11:8], asc[15:12]};
`else
        return asc;
`endif
    endfunction

    // reference latency line: each sampled vector emerges LAT edges later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe.delete();
        end else begin
            pipe.push_back('{v: in_valid, d: ref_sort({i1, i2, i3, i4})});
            if (pipe.size() > LAT) void'(pipe.pop_front());
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && rst_n) begin
            e = (pipe.size() == LAT) ? pipe[0] : '0;
            check("mon_valid", {31'd0, out_valid}, {31'd0, e.v});
            if (e.v) check("mon_lanes", {16'd0, o1, o2, o3, o4}, {16'd0, e.d});
        end
    end

    task automatic drive(input logic v, input logic [15:0] d);
        @(negedge clk);
        in_valid = v;
        {i1, i2, i3, i4} = d;
    endtask

    task automatic directed(input string tag, input logic [15:0] din, input logic [15:0] asc);
        drive(1'b1, din);
        drive(1'b0, 16'h0000);
        repeat (3) @(negedge clk);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_lanes"}, {16'd0, o1, o2, o3, o4}, {16'd0, build_exp(asc)});
        @(negedge clk);
        check({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int hi_cnt;
        logic [15:0] d;
        logic [3:0]  k;

        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_lanes", {16'd0, o1, o2, o3, o4}, 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        directed("basic",   16'h6241, 16'h1246);
        directed("reverse", 16'hFA50, 16'h05AF);
        directed("sorted",  16'h0123, 16'h0123);
        directed("dup",     16'h7373, 16'h3377);
        directed("alleq",   16'h9999, 16'h9999);

        // back-to-back streaming
        drive(1'b1, 16'h4321);
        drive(1'b1, 16'h8181);
        drive(1'b1, 16'h0F0F);
        drive(1'b0, 16'h0000);
        @(negedge clk);
        check("strm0_v", {31'd0, out_valid}, 32'd1);
        check("strm0",   {16'd0, o1, o2, o3, o4}, {16'd0, build_exp(16'h1234)});
        @(negedge clk);
        check("strm1_v", {31'd0, out_valid}, 32'd1);
        check("strm1",   {16'd0, o1, o2, o3, o4}, {16'd0, build_exp(16'h1188)});
        @(negedge clk);
        check("strm2_v", {31'd0, out_valid}, 32'd1);
        check("strm2",   {16'd0, o1, o2, o3, o4}, {16'd0, build_exp(16'h00FF)});
        @(negedge clk);
        check("strm_end", {31'd0, out_valid}, 32'd0);

        // async reset with a vector in flight
        drive(1'b1, 16'h6241);
        drive(1'b0, 16'h0000);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_lanes", {16'd0, o1, o2, o3, o4}, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        hi_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) hi_cnt++;
        end
        check("arst_lost", 32'(hi_cnt), 32'd0);
        directed("post_rst", 16'h6241, 16'h1246);

        // random regression
        for (int n = 0; n < 1000; n++) begin
            for (int j = 0; j < 4; j++) begin
                if ($urandom_range(0, 3) == 0) k = $urandom_range(0, 1) ? 4'hF : 4'h0;
                else                           k = 4'($urandom_range(0, 15));
                d[15-4*j -: 4] = k;
            end
            drive(($urandom_range(0, 9) != 0), d);
        end
        drive(1'b0, 16'h0000);
        repeat (LAT + 2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
